// File: rtl/wb_bram_slave_pkg.sv
// Shared Wishbone cycle-type codes and the slave FSM state type.
package wb_bram_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_e;

  // Only constant and incrementing bursts keep a burst going; every other
  // code (classic, end-of-burst, reserved) means "this is the last beat".
  function automatic logic cti_is_burst(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

endpackage

// File: rtl/wb_bram_slave_ram.sv
// Single-port 32-bit RAM, four byte write enables, registered read-first
// output. Written so synthesis maps it onto block RAM.
module wb_bram_slave_ram #(
  parameter int adr_width = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [3:0]           we_i,
  input  logic [adr_width-1:0] adr_i,
  input  logic [31:0]          dat_i,
  output logic [31:0]          dat_o
);

  localparam int depth = 2 ** adr_width;

  logic [31:0] mem_q [depth];
  logic [31:0] rd_q;

  // Byte-lane writes; contents are never cleared by reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  // Registered read of the old contents; the reset maps onto the BRAM
  // output-register reset so the data bus comes up as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[adr_i];
    end
  end

  assign dat_o = rd_q;

endmodule

// File: rtl/wb_bram_slave.sv
// Wishbone block-RAM slave: classic cycles, constant and incrementing
// bursts, registered acknowledge.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | no access in flight; a request is acked next cycle
//   ST_SINGLE | classic ack cycle; always returns to idle afterwards
//   ST_BURST  | burst ack cycle; stays while cti keeps the burst open
module wb_bram_slave
  import wb_bram_slave_pkg::*;
#(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [adr_width-1:0]   badr_q, badr_d;
  logic [adr_width-1:0]   adr_idx;
  logic [adr_width-1:0]   ram_adr;
  logic [3:0]             ram_we;
  logic                   req;
  logic                   unused_adr_bits;

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_idx = wb_adr_i[adr_width+1:2];

  assign unused_adr_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  // A beat is written only in its ack cycle; reset suppresses the write.
  assign ram_we = (ack_q & req & wb_we_i & ~sys_rst) ? wb_sel_i : 4'b0000;

  // Next-state, ack and burst-address logic. The RAM address normally
  // follows the bus; during a read burst it follows the advanced burst
  // address so the next beat's data is ready in the following cycle.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    badr_d  = badr_q;
    ram_adr = adr_idx;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          ack_d   = 1'b1;
          badr_d  = adr_idx;
          state_d = cti_is_burst(wb_cti_i) ? ST_BURST : ST_SINGLE;
        end
      end
      ST_SINGLE: begin
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (req && cti_is_burst(wb_cti_i)) begin
          ack_d = 1'b1;
          if (wb_cti_i == CTI_INCR) begin
            badr_d = badr_q + adr_width'(1);
          end
          if (!wb_we_i) begin
            ram_adr = badr_d;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, ack and burst-address registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      badr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      badr_q  <= badr_d;
    end
  end

  wb_bram_slave_ram #(
    .adr_width (adr_width)
  ) u_ram (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .we_i  (ram_we),
    .adr_i (ram_adr),
    .dat_i (wb_dat_i),
    .dat_o (wb_dat_o)
  );

  assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Self-checking bench for wb_bram_slave with a small (16-word) RAM so
// wrap-around is easy to reach. Memory contents are tracked in a plain
// array updated with byte-lane merges whenever a write beat is acked.
module tb_wb_bram_slave;
  import wb_bram_slave_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] beat_dat [16];
  logic [3:0]  beat_sel [16];
  logic        obs_ack [16];
  logic [31:0] obs_dat [16];
  logic        obs_tail;
  logic        c_ack1, c_ack2;
  logic [31:0] c_dat;

  always #5 sys_clk = ~sys_clk;

  wb_bram_slave #(.adr_width(AW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_cti_i (wb_cti_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_sel_i = 4'h0; wb_adr_i = '0; wb_dat_i = '0;
  endtask

  // Byte address for a word with random ignored bits around the index.
  function automatic logic [31:0] byte_adr(input int w);
    logic [31:0] a;
    a = $urandom();
    a[AW+1:2] = 4'(w % DEPTH);
    return a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Classic cycle: stb stays high through the ack cycle and one more cycle.
  task automatic classic(input int w, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, input logic [2:0] cti);
    wb_adr_i = byte_adr(w); wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_cti_i = cti; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    c_ack1 = wb_ack_o; c_dat = wb_dat_o;
    tick();
    c_ack2 = wb_ack_o;
    bus_idle();
  endtask

  // Burst of n beats; optionally the master drops stb instead of ending.
  task automatic burst(input int w0, input logic we, input int n, input logic [2:0] mode,
                       input logic [2:0] last_cti, input bit abort);
    int w;
    for (int i = 0; i < n; i++) begin
      w = (mode == CTI_INCR) ? (w0 + i) % DEPTH : w0;
      wb_adr_i = byte_adr(w); wb_dat_i = beat_dat[i]; wb_sel_i = beat_sel[i];
      wb_we_i = we; wb_cti_i = (!abort && i == n - 1) ? last_cti : mode;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      if (i == 0) tick();
      obs_ack[i] = wb_ack_o; obs_dat[i] = wb_dat_o;
      tick();
    end
    if (abort) begin
      bus_idle();
      tick();
    end
    obs_tail = wb_ack_o;
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    sys_rst = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(); tick(); tick();
    n_total++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
    n_total++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
    sys_rst = 1'b0; bus_idle();
    tick();
  endtask

  task automatic test_fill();
    for (int w = 0; w < DEPTH; w++) begin
      model[w] = $urandom();
      classic(w, 1'b1, model[w], 4'hf, CTI_CLASSIC);
      n_total++; if (c_ack1 !== 1'b1) begin n_bad++; $display("FAIL fill_ack w=%0d: got %b want 1", w, c_ack1); end
      n_total++; if (c_ack2 !== 1'b0) begin n_bad++; $display("FAIL fill_noack2 w=%0d: got %b want 0", w, c_ack2); end
    end
    for (int w = 0; w < DEPTH; w++) begin
      classic(w, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
      n_total++; if (c_dat !== model[w]) begin n_bad++; $display("FAIL fill_read w=%0d: got %h want %h", w, c_dat, model[w]); end
    end
  endtask

  task automatic test_classic();
    classic(4, 1'b1, 32'hDEADBEEF, 4'hf, CTI_CLASSIC);
    model[4] = 32'hDEADBEEF;
    n_total++; if (c_ack1 !== 1'b1 || c_ack2 !== 1'b0) begin n_bad++; $display("FAIL classic_wr_ack: got %b%b want 10", c_ack1, c_ack2); end
    classic(4, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
    n_total++; if (c_ack1 !== 1'b1 || c_ack2 !== 1'b0) begin n_bad++; $display("FAIL classic_rd_ack: got %b%b want 10", c_ack1, c_ack2); end
    n_total++; if (c_dat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL classic_rd_dat: got %h want deadbeef", c_dat); end
  endtask

  task automatic test_byte_enable();
    classic(4, 1'b1, 32'h11223344, 4'b0101, CTI_CLASSIC);
    model[4] = merge(model[4], 32'h11223344, 4'b0101);
    classic(4, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
    n_total++; if (c_dat !== 32'hDE22BE44) begin n_bad++; $display("FAIL byte_en: got %h want de22be44", c_dat); end
    classic(4, 1'b1, 32'hFFFFFFFF, 4'b0000, CTI_CLASSIC);
    n_total++; if (c_ack1 !== 1'b1) begin n_bad++; $display("FAIL sel0_ack: got %b want 1", c_ack1); end
    classic(4, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
    n_total++; if (c_dat !== model[4]) begin n_bad++; $display("FAIL sel0_nowrite: got %h want %h", c_dat, model[4]); end
  endtask

  task automatic test_incr_read();
    for (int i = 0; i < 4; i++) begin
      model[4+i] = 32'(i + 1);
      classic(4 + i, 1'b1, model[4+i], 4'hf, CTI_CLASSIC);
    end
    burst(4, 1'b0, 4, CTI_INCR, CTI_END, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (obs_ack[i] !== 1'b1) begin n_bad++; $display("FAIL incr_ack beat=%0d: got %b want 1", i, obs_ack[i]); end
      n_total++; if (obs_dat[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL incr_dat beat=%0d: got %h want %h", i, obs_dat[i], 32'(i + 1)); end
    end
    n_total++; if (obs_tail !== 1'b0) begin n_bad++; $display("FAIL incr_tail: got %b want 0", obs_tail); end
  endtask

  task automatic test_wrap();
    int wl [3];
    wl[0] = 15; wl[1] = 0; wl[2] = 1;
    burst(15, 1'b0, 3, CTI_INCR, CTI_END, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (obs_dat[i] !== model[wl[i]]) begin n_bad++; $display("FAIL wrap_rd beat=%0d: got %h want %h", i, obs_dat[i], model[wl[i]]); end
    end
    for (int i = 0; i < 4; i++) begin beat_dat[i] = $urandom(); beat_sel[i] = 4'hf; end
    burst(14, 1'b1, 4, CTI_INCR, CTI_END, 1'b0);
    for (int i = 0; i < 4; i++) model[(14 + i) % DEPTH] = beat_dat[i];
    for (int i = 0; i < 4; i++) begin
      classic((14 + i) % DEPTH, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
      n_total++; if (c_dat !== model[(14 + i) % DEPTH]) begin n_bad++; $display("FAIL wrap_wr w=%0d: got %h want %h", (14 + i) % DEPTH, c_dat, model[(14 + i) % DEPTH]); end
    end
  endtask

  task automatic test_const_write();
    beat_dat[0] = 32'hAAAA0001; beat_dat[1] = 32'hBBBB0002; beat_dat[2] = 32'hCCCC0003;
    for (int i = 0; i < 3; i++) beat_sel[i] = 4'hf;
    burst(8, 1'b1, 3, CTI_CONST, CTI_END, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (obs_ack[i] !== 1'b1) begin n_bad++; $display("FAIL const_ack beat=%0d: got %b want 1", i, obs_ack[i]); end
    end
    n_total++; if (obs_tail !== 1'b0) begin n_bad++; $display("FAIL const_tail: got %b want 0", obs_tail); end
    model[8] = 32'hCCCC0003;
    for (int w = 8; w < 11; w++) begin
      classic(w, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
      n_total++; if (c_dat !== model[w]) begin n_bad++; $display("FAIL const_word w=%0d: got %h want %h", w, c_dat, model[w]); end
    end
  endtask

  task automatic test_abort();
    burst(2, 1'b0, 2, CTI_INCR, CTI_END, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_total++; if (obs_dat[i] !== model[2+i]) begin n_bad++; $display("FAIL abort_dat beat=%0d: got %h want %h", i, obs_dat[i], model[2+i]); end
    end
    n_total++; if (obs_tail !== 1'b0) begin n_bad++; $display("FAIL abort_tail: got %b want 0", obs_tail); end
    classic(5, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
    n_total++; if (c_ack1 !== 1'b1 || c_dat !== model[5]) begin n_bad++; $display("FAIL abort_idle: got ack=%b dat=%h want ack=1 dat=%h", c_ack1, c_dat, model[5]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d [3];
    int w0;
    w0 = 10;
    for (int i = 0; i < 3; i++) d[i] = ~model[w0 + i];
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hf; wb_cti_i = CTI_INCR;
    wb_adr_i = byte_adr(w0); wb_dat_i = d[0];
    tick();
    n_total++; if (wb_ack_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_ack0: got %b want 1", wb_ack_o); end
    tick();
    wb_adr_i = byte_adr(w0 + 1); wb_dat_i = d[1];
    n_total++; if (wb_ack_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_ack1: got %b want 1", wb_ack_o); end
    tick();
    wb_adr_i = byte_adr(w0 + 2); wb_dat_i = d[2]; sys_rst = 1'b1;
    tick();
    n_total++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack: got %b want 0", wb_ack_o); end
    n_total++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_dat: got %h want 0", wb_dat_o); end
    sys_rst = 1'b0; bus_idle();
    tick();
    model[w0] = d[0]; model[w0 + 1] = d[1];
    for (int i = 0; i < 3; i++) begin
      classic(w0 + i, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
      n_total++; if (c_dat !== model[w0 + i]) begin n_bad++; $display("FAIL rstmid_word w=%0d: got %h want %h", w0 + i, c_dat, model[w0 + i]); end
    end
  endtask

  task automatic test_back_to_back();
    int wa [3];
    for (int i = 0; i < 3; i++) wa[i] = $urandom_range(0, DEPTH - 1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hf; wb_cti_i = CTI_CLASSIC;
    for (int i = 0; i < 3; i++) begin
      wb_adr_i = byte_adr(wa[i]);
      tick();
      n_total++; if (wb_ack_o !== 1'b1 || wb_dat_o !== model[wa[i]]) begin n_bad++; $display("FAIL b2b_ack i=%0d: got ack=%b dat=%h want ack=1 dat=%h", i, wb_ack_o, wb_dat_o, model[wa[i]]); end
      tick();
      n_total++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL b2b_gap i=%0d: got %b want 0", i, wb_ack_o); end
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [2:0] cl_cti [6];
    int kind, w0, n, w;
    logic we, ab;
    logic [2:0] mode, last;
    logic [31:0] d;
    logic [3:0] s;
    cl_cti[0] = 3'b000; cl_cti[1] = 3'b011; cl_cti[2] = 3'b100;
    cl_cti[3] = 3'b101; cl_cti[4] = 3'b110; cl_cti[5] = 3'b111;
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 3);
      w0 = $urandom_range(0, DEPTH - 1);
      we = 1'($urandom_range(0, 1));
      if (kind < 2) begin
        d = $urandom(); s = 4'($urandom_range(0, 15));
        classic(w0, we, d, s, cl_cti[$urandom_range(0, 5)]);
        n_total++; if (c_ack1 !== 1'b1 || c_ack2 !== 1'b0) begin n_bad++; $display("FAIL rnd_cl_ack t=%0d: got %b%b want 10", t, c_ack1, c_ack2); end
        if (we) model[w0] = merge(model[w0], d, s);
        else begin
          n_total++; if (c_dat !== model[w0]) begin n_bad++; $display("FAIL rnd_cl_dat t=%0d w=%0d: got %h want %h", t, w0, c_dat, model[w0]); end
        end
      end else begin
        n = $urandom_range(1, 6);
        mode = (kind == 2) ? CTI_INCR : CTI_CONST;
        last = $urandom_range(0, 1) ? CTI_END : CTI_CLASSIC;
        ab = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < n; i++) begin beat_dat[i] = $urandom(); beat_sel[i] = 4'($urandom_range(0, 15)); end
        burst(w0, we, n, mode, last, ab);
        for (int i = 0; i < n; i++) begin
          w = (mode == CTI_INCR) ? (w0 + i) % DEPTH : w0;
          n_total++; if (obs_ack[i] !== 1'b1) begin n_bad++; $display("FAIL rnd_bu_ack t=%0d beat=%0d: got %b want 1", t, i, obs_ack[i]); end
          if (we) model[w] = merge(model[w], beat_dat[i], beat_sel[i]);
          else begin
            n_total++; if (obs_dat[i] !== model[w]) begin n_bad++; $display("FAIL rnd_bu_dat t=%0d beat=%0d: got %h want %h", t, i, obs_dat[i], model[w]); end
          end
        end
        n_total++; if (obs_tail !== 1'b0) begin n_bad++; $display("FAIL rnd_bu_tail t=%0d: got %b want 0", t, obs_tail); end
      end
    end
    for (int w2 = 0; w2 < DEPTH; w2++) begin
      classic(w2, 1'b0, 32'h0, 4'hf, CTI_CLASSIC);
      n_total++; if (c_dat !== model[w2]) begin n_bad++; $display("FAIL rnd_final w=%0d: got %h want %h", w2, c_dat, model[w2]); end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_fill();
    test_classic();
    test_byte_enable();
    test_incr_read();
    test_wrap();
    test_const_write();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_bram_slave.md
Name: wb_bram_slave

Overview:
- Wishbone responder: on-chip block RAM slave attached to one slave port of the conbus interconnect.
- Supports classic cycles plus constant (CTI 001) and incrementing (CTI 010) bursts. Incrementing bursts return one beat per cycle.
- Acknowledge is always registered, never combinational from stb. This keeps it compatible with the interconnect's registered slave-select on the read-data mux.

Parameters:
- adr_width, 11, word-address bits; depth = 2**adr_width 32-bit words.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- sys_rst  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address; bits [adr_width+1:2] index the RAM; other bits ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1.
- wb_sel_i  in  4  byte enables; bit n covers dat[8n+7:8n].
- wb_cti_i  in  3  cycle type: 000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst; others treated as 000.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  registered acknowledge.

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, FSM=IDLE, burst address=0. RAM contents are not cleared.
- Request: req = wb_cyc_i & wb_stb_i.
- FSM states: IDLE, SINGLE, BURST.
- IDLE:
  - on req, RAM read issued at wb_adr_i word index; wb_ack_o=1 next cycle.
  - cti 001 or 010 -> BURST; otherwise -> SINGLE.
  - burst address register loads wb_adr_i word index.
- SINGLE:
  - ack high for exactly one cycle, then ack=0 and -> IDLE.
  - The master's stb is still high in that ack cycle and must not produce a second ack.
  - Minimum classic cycle: 2 cycles request-to-ack-drop; back-to-back classic throughput is 1 access per 2 cycles.
- BURST:
  - ack held high while req=1 and the current beat's cti is not 111.
  - Each ack cycle, burst address advances by +1 word (CTI 010) or +0 (CTI 001), modulo depth. A RAM read of the new address is issued the same cycle, so the next beat's data is ready at the next ack.
  - Beat with cti=111 acked: ack=0 next cycle, -> IDLE.
  - req drops mid-burst: ack=0 next cycle, -> IDLE; no wait beats are inserted.
- Writes:
  - committed on every cycle where wb_ack_o & req & wb_we_i.
  - address is the current wb_adr_i word index, bytes gated by wb_sel_i.
  - data is the current wb_dat_i, which the master holds stable through the ack cycle.
  - sel=0000 is acked but writes nothing.
- Reads:
  - synchronous RAM; wb_dat_o is the registered RAM output.
  - during write cycles wb_dat_o is undefined to the master.
  - read-during-write to the same address returns old data (read-first).
- Wrap-around: incrementing burst from the top word continues at word 0.
- Reset mid-operation: sys_rst overrides everything; ack=0 on the next edge and no write is committed in the reset cycle.
- Master changing cti from 010 to 000 mid-burst: treated as final beat (same as 111).
- Latency: first ack 1 cycle after req in IDLE; burst steady state 1 beat/cycle.

Decomposition:
- Shared include conbus_defs.vh: CTI codes CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111; also used by the interconnect and by masters.
- Sub-module wb_bram_slave_ram: single-port 32-bit RAM with 4 byte write enables and synchronous read-first output, sized by adr_width, so it infers block RAM.
- The top level holds only the FSM, burst address counter and ack register.

Test Plan:
- Classic write then read: write 0xDEADBEEF sel=1111 adr=0x10, then read adr=0x10 -> ack 1 cycle after each stb, one-cycle ack pulse, read returns 0xDEADBEEF.
- Byte enables: over 0xDEADBEEF, write 0x11223344 sel=0101 -> readback 0xDE22BE44.
- Incrementing read burst: preload words 4..7 = 1,2,3,4; burst read from 0x10 with cti 010,010,010,111 -> ack high 4 consecutive cycles, data 1,2,3,4, ack low next cycle.
- Wrap: adr_width=4, incrementing read burst of 3 beats from word 15 -> data from words 15,0,1.
- Abort and reset: stb dropped after beat 2 of an incrementing burst -> ack low next cycle, FSM IDLE. Separately, sys_rst asserted mid write burst -> ack=0 next edge, the beat in the reset cycle is not written.
- Constant-address write burst (cti 001): 3 beats to adr 0x20 with data A,B,C -> 3 consecutive acks, word 8 = C.
